add_issue_ctl: RTL and testbench
================================

# add_issue_ctl

Issue/return controller on the initiator side of the fixed-latency 64-bit add primitive. Accepts add requests on a valid/ready interface, drives the primitive's `a/b/htId/vld` inputs, and captures the primitive's `res/htId/vld` outputs into a result FIFO. It presents results downstream on a valid/ready interface. The primitive cannot stall, so a credit counter guarantees that every issued operation has a FIFO slot reserved before it is issued.

## Interface
- `LATENCY`, 5, cycles from primitive `vld` in to `vld` out; legal range 1..31.
- `DEPTH`, 8, result FIFO entries; power of 2, 2..64.

- `ck`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `i_req_vld`  in  1  request valid
- `i_req_a`, `i_req_b`  in  64  operands
- `i_req_htId`  in  7  thread id
- `o_req_rdy`  out  1  request accepted when `i_req_vld & o_req_rdy`
- `o_prim_a`, `o_prim_b`  out  64  to primitive
- `o_prim_htId`  out  7  to primitive
- `o_prim_vld`  out  1  to primitive
- `i_prim_res`  in  64  from primitive
- `i_prim_htId`  in  7  from primitive
- `i_prim_vld`  in  1  from primitive
- `o_rsp_vld`  out  1  result valid
- `o_rsp_res`  out  64  sum
- `o_rsp_htId`  out  7  thread id
- `i_rsp_rdy`  in  1  result consumed when `o_rsp_vld & i_rsp_rdy`
- `o_busy`  out  1  any credit held or drain window active
- `o_err`  out  1  sticky protocol error (see Configuration)

## Operation
- **Issue.** On accept, `i_req_a/b/htId` are registered onto `o_prim_*` and `o_prim_vld` is 1 for exactly one cycle. With no accept, `o_prim_vld` is 0 and the `o_prim` data fields hold their previous values.
- **Credits.** `cnt` (0..DEPTH) counts in-flight operations plus FIFO occupancy.
  - It increments on accept and decrements on pop. Accept and pop in the same cycle leave it unchanged.
  - `o_req_rdy = !rst & (drain == 0) & (cnt < DEPTH)`. It depends only on registers and has no combinational path from `i_rsp_rdy`.
- **Capture.** `i_prim_vld` writes `{i_prim_res, i_prim_htId}` into the FIFO at the write pointer, except while the drain window is active.
- **FIFO.**
  - Read and write pointers are `log2(DEPTH)` bits and wrap modulo DEPTH. A separate count distinguishes full from empty.
  - Output is first-word fall-through: `o_rsp_*` reflect the head entry whenever `o_rsp_vld` = 1.
  - A simultaneous write and pop on a full or empty FIFO is legal and leaves the count unchanged.
  - Because of the credit counter, a write to a full FIFO cannot occur with a correct primitive.
- **Drain window.**
  - The primitive has no reset, so stale valids may emerge after `rst`.
  - `drain` is loaded with LATENCY while `rst` = 1 and decrements to 0 afterwards.
  - While `drain != 0`, `i_prim_vld` is ignored and no requests are accepted.
- **Reset values.** `o_req_rdy`=0, `o_prim_vld`=0, `o_prim_a/b/htId`=0, `o_rsp_vld`=0, `o_busy`=1 (drain active), `o_err`=0, `cnt`=0, FIFO empty, pointers 0. `o_rsp_res` and `o_rsp_htId` are don't-care while `o_rsp_vld`=0.
- **Reset mid-operation.** All in-flight and buffered results are discarded, and no response is emitted for them.

## Timing
- Accept at edge E. `o_prim_vld`=1 during cycle E+1.
- The primitive result arrives during cycle E+1+LATENCY and is written at that cycle's closing edge.
- `o_rsp_vld`=1 from cycle E+2+LATENCY, provided the FIFO was previously empty. Request-to-response latency is therefore LATENCY+2 cycles.
- The credit is released at the pop edge. `o_req_rdy` rises in the following cycle.
- Throughput is one request per cycle while credits remain. Sustained full rate requires `DEPTH >= LATENCY+2`.
- After `rst` falls at edge R, `o_req_rdy` first rises in cycle R+LATENCY.

## Configuration
- **`ADD_ISSUE_CHK_EN` defined:**
  - A LATENCY-deep shift register carries `{o_prim_vld, o_prim_htId}`.
  - Each cycle outside the drain window, `o_err` is set (sticky until `rst`) if `i_prim_vld` differs from the delayed vld, or if both are 1 and `i_prim_htId` differs from the delayed htId.
  - `o_err` is also set on an attempted write to a full FIFO; the data is dropped.
- **Not defined:** `o_err` is tied to 0 and the checker logic is absent. Datapath behaviour is otherwise identical.

## Test plan
- **Single op.** After reset drain, request a=5, b=7, htId=3 with `i_rsp_rdy`=1 and an ideal 5-cycle primitive model. Expect `o_prim_vld` exactly 1 cycle after accept; expect `o_rsp_vld` with res=12, htId=3 exactly 7 cycles after accept; `o_err`=0.
- **Streaming.** Issue 20 back-to-back requests (a=i, b=2^63, htId=i) with `i_rsp_rdy`=1 and DEPTH=8. Expect `o_req_rdy` to stay 1, responses in order with res=i+2^63, and one response per cycle.
- **Backpressure.** Hold `i_rsp_rdy`=0 and offer 12 requests. Expect exactly 8 accepted, then `o_req_rdy`=0. Release `i_rsp_rdy`: expect 8 responses in order, then the remaining 4 accepted. FIFO pointer wrap is covered; no loss or duplication.
- **Wrap overflow.** Request a=2^64-1, b=1. Expect res=0.
- **Reset mid-flight.** Issue 3 ops, assert `rst` for 1 cycle, and have the model emit the 3 stale valids afterwards. Expect no `o_rsp_vld`, `o_req_rdy`=0 for LATENCY cycles, then normal operation; `o_err`=0.
- **Checker (`ADD_ISSUE_CHK_EN`).** The model corrupts the returned htId (3→4). Expect `o_err`=1, held until `rst`. Without the macro, expect `o_err`=0.

Source files
------------

// File: rtl/add_issue_ctl.sv
// Issue/return controller for a fixed-latency 64-bit add primitive with a credit-guarded result FIFO.
// Defining ADD_ISSUE_CHK_EN adds the return-protocol checker that drives o_err.
module add_issue_ctl #(
    parameter int LATENCY = 5,
    parameter int DEPTH   = 8
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        i_req_vld,
    input  logic [63:0] i_req_a,
    input  logic [63:0] i_req_b,
    input  logic [6:0]  i_req_htId,
    output logic        o_req_rdy,
    output logic [63:0] o_prim_a,
    output logic [63:0] o_prim_b,
    output logic [6:0]  o_prim_htId,
    output logic        o_prim_vld,
    input  logic [63:0] i_prim_res,
    input  logic [6:0]  i_prim_htId,
    input  logic        i_prim_vld,
    output logic        o_rsp_vld,
    output logic [63:0] o_rsp_res,
    output logic [6:0]  o_rsp_htId,
    input  logic        i_rsp_rdy,
    output logic        o_busy,
    output logic        o_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [63:0] res;
        logic [6:0]  ht_id;
    } entry_t;

    logic [4:0]    drain;
    logic [CW-1:0] cnt;
    logic [CW-1:0] fill;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    entry_t        mem [DEPTH];

    logic accept;
    logic pop;
    logic capture;
    logic full;
    logic write;

    // Ready is formed from registers and rst only, so it never depends on i_rsp_rdy.
    assign o_req_rdy = !rst && (drain == '0) && (cnt < CW'(DEPTH));
    assign accept    = i_req_vld && o_req_rdy;
    assign o_rsp_vld = (fill != '0);
    assign pop       = o_rsp_vld && i_rsp_rdy;
    assign full      = (fill == CW'(DEPTH));
    assign capture   = !rst && i_prim_vld && (drain == '0);
    assign write     = capture && (!full || pop);
    assign o_rsp_res  = mem[rd_ptr].res;
    assign o_rsp_htId = mem[rd_ptr].ht_id;
    assign o_busy     = rst || (cnt != '0) || (drain != '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ck) begin
        if (rst) begin
            drain <= 5'(LATENCY);
            cnt   <= '0;
        end else begin
            if (drain != '0) begin
                drain <= drain - 5'd1;
            end
            if (accept && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (!accept && pop) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            o_prim_vld  <= 1'b0;
            o_prim_a    <= '0;
            o_prim_b    <= '0;
            o_prim_htId <= '0;
        end else begin
            o_prim_vld <= accept;
            if (accept) begin
                o_prim_a    <= i_req_a;
                o_prim_b    <= i_req_b;
                o_prim_htId <= i_req_htId;
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (write && !pop) begin
                fill <= fill + CW'(1);
            end else if (!write && pop) begin
                fill <= fill - CW'(1);
            end
        end
    end

    // NOTE: FIFO storage is deliberately not reset; fill gates o_rsp_vld so stale entries are never presented.
    always_ff @(posedge ck) begin
        if (write) begin
            mem[wr_ptr] <= '{res: i_prim_res, ht_id: i_prim_htId};
        end
    end

`ifdef ADD_ISSUE_CHK_EN
    typedef struct packed {
        logic       vld;
        logic [6:0] ht_id;
    } tag_t;

    tag_t dly [LATENCY];
    tag_t dly_out;
    logic mismatch;
    logic overflow;

    assign dly_out  = dly[LATENCY-1];
    assign overflow = i_prim_vld && full && !pop;

    // NOTE: combinational block assigns its output first so no latch can be inferred.
    always_comb begin
        mismatch = 1'b0;
        if (i_prim_vld != dly_out.vld) begin
            mismatch = 1'b1;
        end else if (i_prim_vld && (i_prim_htId != dly_out.ht_id)) begin
            mismatch = 1'b1;
        end
    end

    // The delay line mirrors the primitive pipeline so each return can be matched to its issue.
    always_ff @(posedge ck) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                dly[i] <= '0;
            end
            o_err <= 1'b0;
        end else begin
            dly[0] <= '{vld: o_prim_vld, ht_id: o_prim_htId};
            for (int i = 1; i < LATENCY; i++) begin
                dly[i] <= dly[i-1];
            end
            if ((drain == '0) && (mismatch || overflow)) begin
                o_err <= 1'b1;
            end
        end
    end
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_add_issue_ctl.sv
// Self-checking bench for add_issue_ctl: ideal primitive model plus a queue-based response scoreboard.
// Compile with ADD_ISSUE_CHK_EN defined to expect o_err on a corrupted return htId.
module tb_add_issue_ctl;

    localparam int LATENCY = 5;
    localparam int DEPTH   = 8;
`ifdef ADD_ISSUE_CHK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        i_req_vld = 1'b0;
    logic [63:0] i_req_a = '0;
    logic [63:0] i_req_b = '0;
    logic [6:0]  i_req_htId = '0;
    logic        o_req_rdy;
    logic [63:0] o_prim_a;
    logic [63:0] o_prim_b;
    logic [6:0]  o_prim_htId;
    logic        o_prim_vld;
    logic [63:0] i_prim_res;
    logic [6:0]  i_prim_htId;
    logic        i_prim_vld;
    logic        o_rsp_vld;
    logic [63:0] o_rsp_res;
    logic [6:0]  o_rsp_htId;
    logic        i_rsp_rdy = 1'b1;
    logic        o_busy;
    logic        o_err;

    always #5 ck = ~ck;

    add_issue_ctl #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .ck(ck), .rst(rst),
        .i_req_vld(i_req_vld), .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_htId(i_req_htId),
        .o_req_rdy(o_req_rdy),
        .o_prim_a(o_prim_a), .o_prim_b(o_prim_b), .o_prim_htId(o_prim_htId), .o_prim_vld(o_prim_vld),
        .i_prim_res(i_prim_res), .i_prim_htId(i_prim_htId), .i_prim_vld(i_prim_vld),
        .o_rsp_vld(o_rsp_vld), .o_rsp_res(o_rsp_res), .o_rsp_htId(o_rsp_htId), .i_rsp_rdy(i_rsp_rdy),
        .o_busy(o_busy), .o_err(o_err)
    );

    // Ideal non-resettable primitive: result and htId appear LATENCY cycles after vld in.
    typedef struct packed {
        logic        vld;
        logic [63:0] res;
        logic [6:0]  ht_id;
        logic        bad;
    } prim_t;

    prim_t pipe [LATENCY] = '{default: '0};
    logic  corrupt_mode = 1'b0;

    always @(posedge ck) begin
        pipe[0] <= '{vld: o_prim_vld, res: o_prim_a + o_prim_b,
                     ht_id: (corrupt_mode && o_prim_htId == 7'd3) ? 7'd4 : o_prim_htId,
                     bad: corrupt_mode && o_prim_vld && o_prim_htId == 7'd3};
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end

    assign i_prim_vld  = pipe[LATENCY-1].vld;
    assign i_prim_res  = pipe[LATENCY-1].res;
    assign i_prim_htId = pipe[LATENCY-1].ht_id;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard: expected responses in issue order, credits = accepted minus popped.
    typedef struct packed {
        logic [63:0] res;
        logic [6:0]  ht_id;
    } rsp_t;

    rsp_t        exp_q[$];
    int          outstanding = 0;
    int          since_rst = 0;
    int          cycle = 0;
    int          n_rsp = 0;
    int          mark_n = -1;
    int          first_pop_cycle = 0;
    int          last_pop_cycle = 0;
    logic        exp_err = 1'b0;
    logic        acc_prev = 1'b0;
    logic        mon_acc;
    logic        mon_pop;
    logic [63:0] prev_a = '0;
    logic [63:0] prev_b = '0;
    logic [6:0]  prev_ht = '0;

    always @(negedge ck) begin
        cycle = cycle + 1;
        if (rst) begin
            exp_q.delete();
            outstanding = 0;
            since_rst   = 0;
            acc_prev    = 1'b0;
            exp_err     = 1'b0;
        end else begin
            check("req_rdy", o_req_rdy, (since_rst >= LATENCY) && (outstanding < DEPTH));
            check("busy", o_busy, (outstanding != 0) || (since_rst < LATENCY));
            check("prim_vld", o_prim_vld, acc_prev);
            if (acc_prev) begin
                check("prim_a", o_prim_a, prev_a);
                check("prim_b", o_prim_b, prev_b);
                check("prim_htid", o_prim_htId, prev_ht);
            end
            check("err", o_err, exp_err);
            mon_pop = 1'b0;
            if (o_rsp_vld) begin
                if (exp_q.size() == 0) begin
                    check("rsp_vld_unexpected", o_rsp_vld, 1'b0);
                end else begin
                    check("rsp_res", o_rsp_res, exp_q[0].res);
                    check("rsp_htid", o_rsp_htId, exp_q[0].ht_id);
                    if (i_rsp_rdy) begin
                        void'(exp_q.pop_front());
                        mon_pop = 1'b1;
                        if (n_rsp == mark_n) first_pop_cycle = cycle;
                        last_pop_cycle = cycle;
                        n_rsp = n_rsp + 1;
                    end
                end
            end
            mon_acc = i_req_vld && o_req_rdy;
            if (mon_acc) begin
                exp_q.push_back('{res: i_req_a + i_req_b,
                                  ht_id: (corrupt_mode && i_req_htId == 7'd3) ? 7'd4 : i_req_htId});
            end
            if (CHK_EN && i_prim_vld && pipe[LATENCY-1].bad && since_rst >= LATENCY) exp_err = 1'b1;
            outstanding = outstanding + int'(mon_acc) - int'(mon_pop);
            acc_prev = mon_acc;
            prev_a   = i_req_a;
            prev_b   = i_req_b;
            prev_ht  = i_req_htId;
            if (since_rst < 1000) since_rst = since_rst + 1;
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [6:0] ht);
        int w = 0;
        i_req_vld  = 1'b1;
        i_req_a    = a;
        i_req_b    = b;
        i_req_htId = ht;
        @(negedge ck);
        while (!o_req_rdy && w < 200) begin
            @(negedge ck);
            w++;
        end
        if (w >= 200) check("send_timeout", o_req_rdy, 1'b1);
        @(posedge ck);
        #1;
        i_req_vld = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int w = 0;
        @(negedge ck);
        while (!o_rsp_vld && w < 100) begin
            @(negedge ck);
            w++;
        end
        if (w >= 100) check({tag, "_timeout"}, o_rsp_vld, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int   lat;
    int   w;
    int   c0;
    int   n0;
    int   idx;
    int   stale;
    logic fire;

    initial begin
        repeat (3) @(posedge ck);
        @(negedge ck);
        check("rst_req_rdy", o_req_rdy, 1'b0);
        check("rst_prim_vld", o_prim_vld, 1'b0);
        check("rst_prim_a", o_prim_a, 64'd0);
        check("rst_prim_htid", o_prim_htId, 7'd0);
        check("rst_rsp_vld", o_rsp_vld, 1'b0);
        check("rst_busy", o_busy, 1'b1);
        check("rst_err", o_err, 1'b0);
        @(posedge ck); #1;
        rst = 1'b0;

        // Drain window after reset release.
        w = 0;
        @(negedge ck);
        while (!o_req_rdy && w < 100) begin @(negedge ck); w++; end
        check("drain_len", w, LATENCY);

        // Single op.
        @(posedge ck); #1;
        send(64'd5, 64'd7, 7'd3);
        @(negedge ck); check("single_prim_vld", o_prim_vld, 1'b1);
        @(negedge ck); check("single_prim_pulse", o_prim_vld, 1'b0);
        lat = 2;
        while (!o_rsp_vld && lat < 100) begin @(negedge ck); lat++; end
        check("single_latency", lat, LATENCY + 2);
        check("single_res", o_rsp_res, 64'd12);
        check("single_htid", o_rsp_htId, 7'd3);
        check("single_err", o_err, 1'b0);
        repeat (4) @(negedge ck);

        // Streaming: 20 back-to-back requests, one response per cycle.
        @(posedge ck); #1;
        c0 = cycle;
        mark_n = n_rsp;
        n0 = n_rsp;
        for (int i = 0; i < 20; i++) send(64'(i), 64'h8000_0000_0000_0000, 7'(i));
        check("stream_issue_cycles", cycle - c0, 20);
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin @(negedge ck); w++; end
        check("stream_rsp_count", n_rsp - n0, 20);
        check("stream_first_rsp", first_pop_cycle - c0, LATENCY + 3);
        check("stream_last_rsp", last_pop_cycle - c0, LATENCY + 22);

        // Backpressure: FIFO fills, credits stop issue, then pointer wrap on release.
        @(posedge ck); #1;
        i_rsp_rdy = 1'b0;
        idx = 0;
        i_req_vld = 1'b1;
        i_req_a = 64'd1000;
        i_req_b = {$urandom, $urandom};
        i_req_htId = 7'd40;
        for (int c = 0; c < 30; c++) begin
            @(negedge ck); fire = o_req_rdy;
            @(posedge ck); #1;
            if (fire) begin
                idx++;
                i_req_a = 64'(1000 + idx);
                i_req_b = {$urandom, $urandom};
                i_req_htId = 7'(40 + idx);
            end
        end
        check("bp_accepted", idx, DEPTH);
        check("bp_rdy_low", o_req_rdy, 1'b0);
        check("bp_rsp_vld", o_rsp_vld, 1'b1);
        n0 = n_rsp;
        i_rsp_rdy = 1'b1;
        w = 0;
        while (idx < 12 && w < 100) begin
            @(negedge ck); fire = o_req_rdy;
            @(posedge ck); #1;
            if (fire) begin
                idx++;
                i_req_a = 64'(1000 + idx);
                i_req_b = {$urandom, $urandom};
                i_req_htId = 7'(40 + idx);
            end
            w++;
        end
        i_req_vld = 1'b0;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin @(negedge ck); w++; end
        check("bp_total_rsp", n_rsp - n0, 12);

        // Random traffic with random backpressure.
        @(posedge ck); #1;
        for (int c = 0; c < 400; c++) begin
            i_req_vld  = ($urandom_range(0, 3) != 0);
            i_req_a    = {$urandom, $urandom};
            i_req_b    = {$urandom, $urandom};
            i_req_htId = 7'($urandom_range(0, 127));
            i_rsp_rdy  = ($urandom_range(0, 2) != 0);
            @(posedge ck); #1;
        end
        i_req_vld = 1'b0;
        i_rsp_rdy = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin @(negedge ck); w++; end
        check("random_drained", exp_q.size(), 0);

        // 64-bit wrap.
        @(posedge ck); #1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 7'd11);
        wait_rsp("wrap");
        check("wrap_res", o_rsp_res, 64'd0);
        check("wrap_htid", o_rsp_htId, 7'd11);
        repeat (3) @(negedge ck);

        // Reset mid-flight: stale primitive returns must be discarded.
        @(posedge ck); #1;
        send(64'd1, 64'd1, 7'd1);
        send(64'd2, 64'd2, 7'd2);
        send(64'd3, 64'd3, 7'd3);
        rst = 1'b1;
        @(posedge ck); #1;
        rst = 1'b0;
        w = 0;
        stale = 0;
        @(negedge ck);
        while (!o_req_rdy && w < 100) begin
            stale += int'(o_rsp_vld);
            @(negedge ck);
            w++;
        end
        check("rst_drain_len", w, LATENCY);
        repeat (2 * LATENCY) begin @(negedge ck); stale += int'(o_rsp_vld); end
        check("rst_no_stale_rsp", stale, 0);
        check("rst_mid_err", o_err, 1'b0);
        @(posedge ck); #1;
        send(64'd100, 64'd200, 7'd9);
        wait_rsp("post_rst");
        check("post_rst_res", o_rsp_res, 64'd300);
        repeat (3) @(negedge ck);

        // Corrupted return htId: flagged only when the checker is built in.
        @(posedge ck); #1;
        corrupt_mode = 1'b1;
        send(64'd10, 64'd20, 7'd3);
        repeat (LATENCY + 4) @(negedge ck);
        check("chk_err_set", o_err, CHK_EN);
        corrupt_mode = 1'b0;
        @(posedge ck); #1;
        send(64'd1, 64'd2, 7'd5);
        repeat (LATENCY + 4) @(negedge ck);
        check("chk_err_sticky", o_err, CHK_EN);
        @(posedge ck); #1;
        rst = 1'b1;
        @(posedge ck); #1;
        rst = 1'b0;
        @(negedge ck);
        check("chk_err_cleared", o_err, 1'b0);
        repeat (LATENCY + 2) @(negedge ck);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
